// File: rtl/reg_wb_buffer.sv
// Register writeback buffer: in-order {dest, data} queue that drains into the register-file write port, with operand forwarding.
// Latency: an entry pushed into an empty buffer is written on the next cycle; operand forwarding is combinational.
// Backpressure: in_ready drops when all DEPTH entries are occupied; hold stalls draining without affecting pushes or forwarding.
module reg_wb_buffer #(
    parameter int DW    = 16,
    parameter int AW    = 3,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_dest,
    input  logic [DW-1:0] in_data,
    input  logic          hold,
    output logic          reg_write_en,
    output logic [AW-1:0] reg_write_dest,
    output logic [DW-1:0] reg_write_data,
    input  logic [AW-1:0] rd_addr_1,
    input  logic [AW-1:0] rd_addr_2,
    input  logic [DW-1:0] rf_data_1,
    input  logic [DW-1:0] rf_data_2,
    output logic [DW-1:0] rd_data_1,
    output logic [DW-1:0] rd_data_2,
    output logic [AW:0]   count
);

    // Pointer width for a power-of-two queue; pointers wrap naturally.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] dest_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic [PW-1:0] idx;

    // Handshake and write-port signals depend only on registered state (plus hold for the strobe).
    assign in_ready       = (cnt != FULL);
    assign reg_write_en   = (cnt != '0) && !hold;
    assign reg_write_dest = dest_q[head];
    assign reg_write_data = data_q[head];
    assign count          = cnt;

    assign push = in_valid && in_ready;
    assign pop  = reg_write_en;

    // Entry storage is not reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            dest_q[tail] <= in_dest;
            data_q[tail] <= in_data;
        end
    end

    // Pointers and occupancy; reset discards every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Forwarding: walk entries oldest to youngest so the youngest matching entry wins.
    // The head being written this cycle is still occupied and is included; an entry
    // pushed on the coming edge is not yet counted and so is not forwarded.
    always_comb begin
        rd_data_1 = rf_data_1;
        rd_data_2 = rf_data_2;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < cnt) begin
                if (dest_q[idx] == rd_addr_1) begin
                    rd_data_1 = data_q[idx];
                end
                if (dest_q[idx] == rd_addr_2) begin
                    rd_data_2 = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_buffer.sv
// Bench for reg_wb_buffer: table of per-cycle vectors plus a streaming wrap sequence.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// All expected values are hand-computed constants in the table or derived from the stream index.
module tb_reg_wb_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_dest;
    logic [15:0] in_data;
    logic        hold;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [2:0]  rd_addr_1;
    logic [2:0]  rd_addr_2;
    logic [15:0] rf_data_1;
    logic [15:0] rf_data_2;
    logic [15:0] rd_data_1;
    logic [15:0] rd_data_2;
    logic [3:0]  count;

    int checks;
    int failures;

    reg_wb_buffer #(.DW(16), .AW(3), .DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_dest        (in_dest),
        .in_data        (in_data),
        .hold           (hold),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .rd_addr_1      (rd_addr_1),
        .rd_addr_2      (rd_addr_2),
        .rf_data_1      (rf_data_1),
        .rf_data_2      (rf_data_2),
        .rd_data_1      (rd_data_1),
        .rd_data_2      (rd_data_2),
        .count          (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        vld;
        logic [2:0]  dest;
        logic [15:0] data;
        logic        hold;
        logic [2:0]  ra1;
        logic [15:0] rf1;
        logic [2:0]  ra2;
        logic [15:0] rf2;
        logic        chk;
        logic        e_rdy;
        logic        e_wen;
        logic [2:0]  e_dest;
        logic [15:0] e_data;
        logic [3:0]  e_cnt;
        logic [15:0] e_rd1;
        logic [15:0] e_rd2;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic rst, input logic vld, input logic [2:0] dest, input logic [15:0] data,
        input logic hold, input logic [2:0] ra1, input logic [15:0] rf1,
        input logic [2:0] ra2, input logic [15:0] rf2,
        input logic chk, input logic e_rdy, input logic e_wen, input logic [2:0] e_dest,
        input logic [15:0] e_data, input logic [3:0] e_cnt,
        input logic [15:0] e_rd1, input logic [15:0] e_rd2);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dest = dest; v.data = data; v.hold = hold;
        v.ra1 = ra1; v.rf1 = rf1; v.ra2 = ra2; v.rf2 = rf2;
        v.chk = chk; v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_dest = e_dest;
        v.e_data = e_data; v.e_cnt = e_cnt; v.e_rd1 = e_rd1; v.e_rd2 = e_rd2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst       = v.rst;
        in_valid  = v.vld;
        in_dest   = v.dest;
        in_data   = v.data;
        hold      = v.hold;
        rd_addr_1 = v.ra1;
        rf_data_1 = v.rf1;
        rd_addr_2 = v.ra2;
        rf_data_2 = v.rf2;
    endtask

    logic [2:0]  got_dest [$];
    logic [15:0] got_data [$];

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; hold = 1'b0;
        rd_addr_1 = '0; rd_addr_2 = '0; rf_data_1 = '0; rf_data_2 = '0;

        //               rst vld dst data     hld ra1 rf1      ra2 rf2      chk rdy wen edst edata    cnt rd1      rd2
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
        // single write: pushed entry not forwarded in its own cycle, written next cycle
        vecs[1]  = mk(0, 1, 3, 16'h1234, 0, 3, 16'hAAAA, 7, 16'h7777, 1, 1, 0, 0, 16'h0000, 0, 16'hAAAA, 16'h7777);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 0, 3, 16'hAAAA, 7, 16'h7777, 1, 1, 1, 3, 16'h1234, 1, 16'h1234, 16'h7777);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 0, 3, 16'hAAAA, 7, 16'h7777, 1, 1, 0, 0, 16'h0000, 0, 16'hAAAA, 16'h7777);
        // fill under hold, fifth push dropped
        vecs[4]  = mk(0, 1, 1, 16'h000A, 1, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 0, 0, 16'h0000, 0, 16'h0F0F, 16'h7777);
        vecs[5]  = mk(0, 1, 2, 16'h000B, 1, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 0, 1, 16'h000A, 1, 16'h0F0F, 16'h7777);
        vecs[6]  = mk(0, 1, 3, 16'h000C, 1, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 0, 1, 16'h000A, 2, 16'h0F0F, 16'h7777);
        vecs[7]  = mk(0, 1, 4, 16'h000D, 1, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 0, 1, 16'h000A, 3, 16'h0F0F, 16'h7777);
        vecs[8]  = mk(0, 1, 5, 16'h000E, 1, 0, 16'h0F0F, 7, 16'h7777, 1, 0, 0, 1, 16'h000A, 4, 16'h0F0F, 16'h7777);
        // release hold: four consecutive writes, then idle
        vecs[9]  = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 1, 0, 1, 1, 16'h000A, 4, 16'h0F0F, 16'h7777);
        vecs[10] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 1, 2, 16'h000B, 3, 16'h0F0F, 16'h7777);
        vecs[11] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 1, 3, 16'h000C, 2, 16'h0F0F, 16'h7777);
        vecs[12] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 1, 4, 16'h000D, 1, 16'h0F0F, 16'h7777);
        vecs[13] = mk(0, 0, 0, 16'h0000, 0, 0, 16'h0F0F, 7, 16'h7777, 1, 1, 0, 0, 16'h0000, 0, 16'h0F0F, 16'h7777);
        // forwarding: youngest of two entries for reg 2 wins, reg 5 falls through
        vecs[14] = mk(0, 1, 2, 16'h1111, 1, 2, 16'h0000, 5, 16'h5555, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h5555);
        vecs[15] = mk(0, 1, 2, 16'h2222, 1, 2, 16'h0000, 5, 16'h5555, 1, 1, 0, 2, 16'h1111, 1, 16'h1111, 16'h5555);
        vecs[16] = mk(0, 0, 0, 16'h0000, 1, 2, 16'h0000, 5, 16'h5555, 1, 1, 0, 2, 16'h1111, 2, 16'h2222, 16'h5555);
        // register 0 is forwarded like any other
        vecs[17] = mk(0, 1, 0, 16'h0BEE, 1, 2, 16'h0000, 0, 16'h5555, 1, 1, 0, 2, 16'h1111, 2, 16'h2222, 16'h5555);
        vecs[18] = mk(0, 0, 0, 16'h0000, 1, 2, 16'h0000, 0, 16'h5555, 1, 1, 0, 2, 16'h1111, 3, 16'h2222, 16'h0BEE);
        // reset with three queued entries and a concurrent push
        vecs[19] = mk(1, 1, 6, 16'h6666, 1, 2, 16'h0000, 0, 16'h5555, 1, 1, 0, 2, 16'h1111, 3, 16'h2222, 16'h0BEE);
        vecs[20] = mk(0, 0, 0, 16'h0000, 0, 2, 16'h0000, 6, 16'h5555, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h5555);
        vecs[21] = mk(0, 0, 0, 16'h0000, 0, 2, 16'h0000, 6, 16'h5555, 1, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'h5555);

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            if (vecs[i].chk) begin
                check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
                check($sformatf("v%0d_write_en", i), 32'(reg_write_en), 32'(vecs[i].e_wen));
                check($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
                check($sformatf("v%0d_rd_data_1", i), 32'(rd_data_1), 32'(vecs[i].e_rd1));
                check($sformatf("v%0d_rd_data_2", i), 32'(rd_data_2), 32'(vecs[i].e_rd2));
                if (vecs[i].e_cnt != 0) begin
                    check($sformatf("v%0d_write_dest", i), 32'(reg_write_dest), 32'(vecs[i].e_dest));
                    check($sformatf("v%0d_write_data", i), 32'(reg_write_data), 32'(vecs[i].e_data));
                end
            end
            @(posedge clk);
            #1;
        end

        // Streaming: two entries queued under hold, then push and pop every cycle
        // across pointer wrap; count must stay 2 and all ten writes arrive in order.
        rst = 1'b0; rd_addr_1 = 3'd0; rd_addr_2 = 3'd0; rf_data_1 = '0; rf_data_2 = '0;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_dest  = 3'(k % 8);
            in_data  = 16'h0100 + 16'(k);
            hold     = (k < 2);
            @(negedge clk);
            if (k >= 2) begin
                check($sformatf("stream_count_k%0d", k), 32'(count), 32'd2);
            end
            if (reg_write_en) begin
                got_dest.push_back(reg_write_dest);
                got_data.push_back(reg_write_data);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        hold     = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (reg_write_en) begin
                got_dest.push_back(reg_write_dest);
                got_data.push_back(reg_write_data);
            end
            @(posedge clk);
            #1;
        end
        check("stream_write_total", 32'(got_dest.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            if (k < got_dest.size()) begin
                check($sformatf("stream_dest_%0d", k), 32'(got_dest[k]), 32'(k % 8));
                check($sformatf("stream_data_%0d", k), 32'(got_data[k]), 32'h0100 + 32'(k));
            end
        end
        @(negedge clk);
        check("stream_final_count", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
